mul_result_buffer: RTL and testbench

Downstream companion of the iterative multiplier in the out-of-order core's MUL functional unit. It captures the destination metadata of the operation issued to the multiplier and pairs it with the 64-bit product when the multiplier reports done. It then selects the low or high word per RV32M opcode and queues the result in a small FIFO. The FIFO arbitrates onto the CDB, freeing the multiplier without waiting for a CDB grant.

---
 rtl/mul_result_buffer.sv | 237 +++++++++++++++++++++++
 tb/tb_mul_result_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_buffer.sv
// mul_result_buffer: pairs multiplier products with the destination metadata
// of the op in flight, selects the RV32M result word and queues results in a
// small FIFO that competes for the CDB independently of the multiplier.

package mul_result_buffer_pkg;

    parameter int BR_TAG_W = 4;

    // Speculation tag: a sign bit plus a mask of outstanding branches.
    typedef struct packed {
        logic                sign;
        logic [BR_TAG_W-1:0] tag;
    } branch_tag_t;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // An entry dies when the kill mask covers it: with equal signs the entry
    // must carry every bit of the kill mask; with opposite signs every bit of
    // the entry must lie inside the kill mask.
    function automatic logic tag_killed(input branch_tag_t e, input branch_tag_t f);
        if (e.sign == f.sign) begin
            return (e.tag & f.tag) == f.tag;
        end
        return (e.tag & f.tag) == e.tag;
    endfunction

endpackage

module mul_result_buffer
    import mul_result_buffer_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [1:0]                 issue_op,
    input  logic [ROB_IDX_W-1:0]       issue_rob_idx,
    input  logic [PREG_W-1:0]          issue_pd,
    input  branch_tag_t                issue_br_tag,
    input  logic                       mul_done,
    input  logic [63:0]                mul_p,
    output logic                       mul_result_taken,
    input  logic                       flush,
    input  branch_tag_t                flush_tag,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output logic [ROB_IDX_W-1:0]       cdb_rob_idx,
    output logic [PREG_W-1:0]          cdb_pd,
    output logic [31:0]                cdb_data,
    output branch_tag_t                cdb_br_tag,
    output logic                       pending_busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [31:0]          data;
        branch_tag_t          br_tag;
    } entry_t;

    // ------------------------------------------------------------------
    // Pending register: metadata of the op currently inside the multiplier
    // ------------------------------------------------------------------
    logic                 pend_valid_q;
    mul_op_e              pend_op_q;
    logic [ROB_IDX_W-1:0] pend_rob_idx_q;
    logic [PREG_W-1:0]    pend_pd_q;
    branch_tag_t          pend_br_tag_q;

    // ------------------------------------------------------------------
    // Result FIFO state
    // ------------------------------------------------------------------
    entry_t               slot_q [DEPTH];
    logic [DEPTH-1:0]     slot_valid_q;
    logic [DEPTH-1:0]     slot_valid_d;
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     occ_q;
    logic [CNT_W-1:0]     occ_d;

    logic                 pend_kill;
    logic                 head_alloc;
    logic                 head_valid;
    logic                 pop;
    logic                 push;
    logic [31:0]          sel_word;
    entry_t               head_e;

    // Kill of the in-flight op this cycle; a killed op is never pushed.
    assign pend_kill = flush & pend_valid_q & tag_killed(pend_br_tag_q, flush_tag);

    // Head slot view: allocated means it still occupies the FIFO, valid means
    // it has not been killed and must be broadcast.
    assign head_e     = slot_q[head_q];
    assign head_alloc = (occ_q != '0);
    assign head_valid = head_alloc & slot_valid_q[head_q];

    // A granted valid head leaves; a killed head drains without a grant.
    // A grant without a request cannot pop a valid slot that is not there.
    assign pop = head_alloc & (~slot_valid_q[head_q] | cdb_grant);

    // Accept the product when the op survives this cycle and there is room,
    // counting the slot the head frees in the same cycle.
    assign push = mul_done & pend_valid_q & ~pend_kill & ((occ_q < DEPTH_C) | pop);

    assign mul_result_taken = push;
    assign pending_busy     = pend_valid_q;

    // Low word for MUL, high word for every MULH variant.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        sel_word = mul_p[63:32];
        case (pend_op_q)
            OP_MUL:  sel_word = mul_p[31:0];
            default: sel_word = mul_p[63:32];
        endcase
    end

    // Track the in-flight op; a new issue in the take cycle overrides the clear.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples values from before this edge, regardless of order.
        if (rst) begin
            pend_valid_q <= 1'b0;
        end else if (issue_valid) begin
            pend_valid_q <= 1'b1;
        end else if (push || pend_kill) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Pending metadata only matters while pend_valid_q is set.
    always_ff @(posedge clk) begin
        if (issue_valid) begin
            pend_op_q      <= mul_op_e'(issue_op);
            pend_rob_idx_q <= issue_rob_idx;
            pend_pd_q      <= issue_pd;
            pend_br_tag_q  <= issue_br_tag;
        end
    end

    // Next valid mask: kill first, then release the popped head, then mark
    // the pushed tail (which wins when a full FIFO pushes and pops together).
    always_comb begin
        slot_valid_d = slot_valid_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tag_killed(slot_q[i].br_tag, flush_tag)) begin
                    slot_valid_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            slot_valid_d[head_q] = 1'b0;
        end
        if (push) begin
            slot_valid_d[tail_q] = 1'b1;
        end
    end

    // Occupancy counts allocated slots, killed-but-not-drained included.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO control registers; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            occ_q        <= occ_d;
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
        end
    end

    // Result payload storage written at the tail on every take.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; the per-slot valid bits and
        // pointers are reset, and payload is never observed while invalid.
        if (push) begin
            slot_q[tail_q] <= '{rob_idx: pend_rob_idx_q,
                                pd:      pend_pd_q,
                                data:    sel_word,
                                br_tag:  pend_br_tag_q};
        end
    end

    // Number of live (unkilled) results held.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(slot_valid_q[i]);
        end
    end

    // CDB request and head fields, zeroed whenever nothing is requested.
    assign cdb_req     = head_valid;
    assign cdb_rob_idx = cdb_req ? head_e.rob_idx : '0;
    assign cdb_pd      = cdb_req ? head_e.pd      : '0;
    assign cdb_data    = cdb_req ? head_e.data    : '0;
    assign cdb_br_tag  = cdb_req ? head_e.br_tag  : '0;

    // The scheduler may only issue while the multiplier is idle or its
    // result leaves in this very cycle.
    illegal_issue_a : assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && pend_valid_q && !push))
        else $error("issue_valid while an op is still pending");

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed bench for mul_result_buffer with hand-computed expected values.

module tb_mul_result_buffer;
    import mul_result_buffer_pkg::*;

    localparam int DEPTH     = 2;
    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;

    logic                   clk;
    logic                   rst;
    logic                   issue_valid;
    logic [1:0]             issue_op;
    logic [ROB_IDX_W-1:0]   issue_rob_idx;
    logic [PREG_W-1:0]      issue_pd;
    branch_tag_t            issue_br_tag;
    logic                   mul_done;
    logic [63:0]            mul_p;
    logic                   mul_result_taken;
    logic                   flush;
    branch_tag_t            flush_tag;
    logic                   cdb_req;
    logic                   cdb_grant;
    logic [ROB_IDX_W-1:0]   cdb_rob_idx;
    logic [PREG_W-1:0]      cdb_pd;
    logic [31:0]            cdb_data;
    branch_tag_t            cdb_br_tag;
    logic                   pending_busy;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    mul_result_buffer #(
        .DEPTH     (DEPTH),
        .ROB_IDX_W (ROB_IDX_W),
        .PREG_W    (PREG_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_op         (issue_op),
        .issue_rob_idx    (issue_rob_idx),
        .issue_pd         (issue_pd),
        .issue_br_tag     (issue_br_tag),
        .mul_done         (mul_done),
        .mul_p            (mul_p),
        .mul_result_taken (mul_result_taken),
        .flush            (flush),
        .flush_tag        (flush_tag),
        .cdb_req          (cdb_req),
        .cdb_grant        (cdb_grant),
        .cdb_rob_idx      (cdb_rob_idx),
        .cdb_pd           (cdb_pd),
        .cdb_data         (cdb_data),
        .cdb_br_tag       (cdb_br_tag),
        .pending_busy     (pending_busy),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op, then raise mul_done with product p and check the take.
    // When taken, mul_done is dropped after the take edge; otherwise it stays high.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [ROB_IDX_W-1:0] rob,
                          input logic [PREG_W-1:0] pd, input branch_tag_t tg,
                          input logic [63:0] p, input logic exp_taken);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_rob_idx = rob;
        issue_pd      = pd;
        issue_br_tag  = tg;
        tick();
        issue_valid = 1'b0;
        mul_done    = 1'b1;
        mul_p       = p;
        #1;
        check({nm, "_taken"}, 64'(mul_result_taken), 64'(exp_taken));
        if (exp_taken) begin
            tick();
            mul_done = 1'b0;
            #1;
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_req"},   64'(cdb_req),      64'd0);
        check({nm, "_data"},  64'(cdb_data),     64'd0);
        check({nm, "_rob"},   64'(cdb_rob_idx),  64'd0);
        check({nm, "_busy"},  64'(pending_busy), 64'd0);
        check({nm, "_count"}, 64'(count),        64'd0);
        check({nm, "_taken"}, 64'(mul_result_taken), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_op      = 2'b00;
        issue_rob_idx = '0;
        issue_pd      = '0;
        issue_br_tag  = '0;
        mul_done      = 1'b0;
        mul_p         = '0;
        flush         = 1'b0;
        flush_tag     = '0;
        cdb_grant     = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle("reset");

        // MUL low word, grant held high from the start.
        cdb_grant = 1'b1;
        run_op("mul_lo", 2'b00, 5'd3, 6'd9, '{sign: 1'b0, tag: 4'b0001},
               64'h0000_0001_FFFF_FFFE, 1'b1);
        check("mul_lo_req",  64'(cdb_req),      64'd1);
        check("mul_lo_data", 64'(cdb_data),     64'hFFFF_FFFE);
        check("mul_lo_rob",  64'(cdb_rob_idx),  64'd3);
        check("mul_lo_pd",   64'(cdb_pd),       64'd9);
        check("mul_lo_tag",  64'(cdb_br_tag),   64'h01);
        check("mul_lo_busy", 64'(pending_busy), 64'd0);
        tick();
        check("mul_lo_cnt",  64'(count),        64'd0);
        check("mul_lo_req0", 64'(cdb_req),      64'd0);

        // MULHU high word.
        run_op("mulhu", 2'b11, 5'd4, 6'd10, '{sign: 1'b0, tag: 4'b0001},
               64'h0000_0001_FFFF_FFFE, 1'b1);
        check("mulhu_data", 64'(cdb_data), 64'h0000_0001);
        tick();

        // MULH high word of all-ones.
        run_op("mulh", 2'b01, 5'd5, 6'd11, '{sign: 1'b0, tag: 4'b0001},
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("mulh_data", 64'(cdb_data), 64'hFFFF_FFFF);
        tick();
        check("mulh_cnt", 64'(count), 64'd0);

        // Fill the FIFO with no grant; third product must wait.
        cdb_grant = 1'b0;
        run_op("fill1", 2'b00, 5'd1, 6'd1, '{sign: 1'b0, tag: 4'b0001}, 64'h0000_0000_0000_0011, 1'b1);
        run_op("fill2", 2'b10, 5'd2, 6'd2, '{sign: 1'b0, tag: 4'b0001}, 64'h0000_0022_0000_0000, 1'b1);
        check("fill_cnt2", 64'(count), 64'd2);
        run_op("fill3", 2'b00, 5'd3, 6'd3, '{sign: 1'b0, tag: 4'b0001}, 64'h0000_0000_0000_0033, 1'b0);
        tick();
        check("fill3_wait",  64'(mul_result_taken), 64'd0);
        check("fill3_busy",  64'(pending_busy),     64'd1);
        cdb_grant = 1'b1;
        #1;
        check("full_pp_taken", 64'(mul_result_taken), 64'd1);
        check("full_pp_head",  64'(cdb_rob_idx),      64'd1);
        check("full_pp_data",  64'(cdb_data),         64'h11);
        tick();
        cdb_grant = 1'b0;
        mul_done  = 1'b0;
        #1;
        check("full_pp_cnt",  64'(count),       64'd2);
        check("full_pp_rob2", 64'(cdb_rob_idx), 64'd2);
        check("full_pp_dat2", 64'(cdb_data),    64'h22);
        cdb_grant = 1'b1;
        tick();
        check("drain_rob3", 64'(cdb_rob_idx), 64'd3);
        check("drain_dat3", 64'(cdb_data),    64'h33);
        tick();
        cdb_grant = 1'b0;
        #1;
        check("drain_cnt", 64'(count), 64'd0);

        // Flush that kills the pending op in the done cycle.
        issue_valid   = 1'b1;
        issue_op      = 2'b00;
        issue_rob_idx = 5'd7;
        issue_pd      = 6'd7;
        issue_br_tag  = '{sign: 1'b0, tag: 4'b0010};
        tick();
        issue_valid = 1'b0;
        mul_done    = 1'b1;
        mul_p       = 64'h5;
        flush       = 1'b1;
        flush_tag   = '{sign: 1'b0, tag: 4'b0010};
        #1;
        check("pkill_taken", 64'(mul_result_taken), 64'd0);
        tick();
        flush    = 1'b0;
        mul_done = 1'b0;
        #1;
        check("pkill_busy", 64'(pending_busy), 64'd0);
        check("pkill_req",  64'(cdb_req),      64'd0);
        check("pkill_cnt",  64'(count),        64'd0);

        // Full FIFO, same-sign flush kills only the head.
        run_op("hk1", 2'b00, 5'd5, 6'd5, '{sign: 1'b0, tag: 4'b0100}, 64'h55, 1'b1);
        run_op("hk2", 2'b00, 5'd6, 6'd6, '{sign: 1'b0, tag: 4'b1000}, 64'h66, 1'b1);
        check("hk_cnt2", 64'(count), 64'd2);
        flush     = 1'b1;
        flush_tag = '{sign: 1'b0, tag: 4'b0100};
        tick();
        flush = 1'b0;
        #1;
        check("hk_req0", 64'(cdb_req), 64'd0);
        check("hk_cnt1", 64'(count),   64'd1);
        tick();
        check("hk_req1", 64'(cdb_req),     64'd1);
        check("hk_rob6", 64'(cdb_rob_idx), 64'd6);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        #1;
        check("hk_cnt0", 64'(count), 64'd0);

        // Full FIFO, opposite-sign flush kills only the head.
        run_op("sk1", 2'b00, 5'd8, 6'd8, '{sign: 1'b1, tag: 4'b0011}, 64'h88, 1'b1);
        run_op("sk2", 2'b00, 5'd9, 6'd9, '{sign: 1'b1, tag: 4'b1000}, 64'h99, 1'b1);
        flush     = 1'b1;
        flush_tag = '{sign: 1'b0, tag: 4'b0111};
        tick();
        flush = 1'b0;
        #1;
        check("sk_req0", 64'(cdb_req), 64'd0);
        check("sk_cnt1", 64'(count),   64'd1);
        tick();
        check("sk_rob9", 64'(cdb_rob_idx), 64'd9);
        check("sk_dat9", 64'(cdb_data),    64'h99);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        #1;

        // Reset with two entries queued and an op pending.
        run_op("r1", 2'b00, 5'd10, 6'd10, '{sign: 1'b0, tag: 4'b0001}, 64'hA, 1'b1);
        run_op("r2", 2'b00, 5'd11, 6'd11, '{sign: 1'b0, tag: 4'b0001}, 64'hB, 1'b1);
        issue_valid   = 1'b1;
        issue_rob_idx = 5'd12;
        tick();
        issue_valid = 1'b0;
        #1;
        check("r_busy", 64'(pending_busy), 64'd1);
        check("r_cnt",  64'(count),        64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_idle("midrst");
        cdb_grant = 1'b1;
        run_op("post", 2'b00, 5'd13, 6'd14, '{sign: 1'b0, tag: 4'b0001},
               64'h1234_5678_9ABC_DEF0, 1'b1);
        check("post_data", 64'(cdb_data),    64'h9ABC_DEF0);
        check("post_rob",  64'(cdb_rob_idx), 64'd13);
        check("post_pd",   64'(cdb_pd),      64'd14);
        tick();
        check("post_cnt", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
